// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern master: counter, walking-one and beat-index
// patterns with packetisation, TLAST/TUSER framing and a packet counter.
module axis_pattern_gen #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_START_COUNT = 32,
  parameter int C_LEN_WIDTH          = 16,
  parameter int C_PKTCNT_WIDTH       = 16
) (
  input  logic                              m_axis_aclk,
  input  logic                              m_axis_aresetn,
  input  logic                              enable,
  input  logic [1:0]                        mode,
  input  logic [7:0]                        step,
  input  logic [C_LEN_WIDTH-1:0]            pkt_len,
  output logic                              busy,
  output logic [C_PKTCNT_WIDTH-1:0]         pkt_count,
  output logic                              m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  input  logic                              m_axis_tready
);

  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int LW = C_LEN_WIDTH;
  localparam int PW = C_PKTCNT_WIDTH;

  localparam logic [15:0]   INIT_LAST = 16'(C_M_AXIS_START_COUNT - 1);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);
  localparam logic [PW-1:0] PKT_ONE   = PW'(1);
  localparam logic [W-1:0]  DATA_ONE  = W'(1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SEND
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   init_cnt_q, init_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    step_q, step_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;

  logic          xfer;
  logic          last_beat;
  logic          start;
  logic [LW-1:0] len_in;
  logic [LW-1:0] beat_nx;
  logic [W-1:0]  step_w;
  logic [W-1:0]  d_adv;

  assign xfer      = tvalid_q & m_axis_tready;
  assign last_beat = (beat_q == (len_q - LEN_ONE));
  assign len_in    = (pkt_len == '0) ? LEN_ONE : pkt_len;
  assign beat_nx   = beat_q + LEN_ONE;
  assign step_w    = W'(step_q);

  // Running value after the current beat transfers (counter modes only)
  always_comb begin
    d_adv = d_q;
    if (mode_q == 2'b00) begin
      d_adv = d_q + step_w;
    end else if (mode_q == 2'b01) begin
      d_adv = d_q - step_w;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mode_d     = mode_q;
    step_d     = step_q;
    len_d      = len_q;
    beat_d     = beat_q;
    d_d        = d_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    busy_d     = busy_q;
    pkt_cnt_d  = pkt_cnt_q;
    start      = 1'b0;

    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        start = enable;
      end
      S_SEND: begin
        if (xfer) begin
          if (!mode_q[1]) begin
            d_d = d_adv;
          end
          if (last_beat) begin
            pkt_cnt_d = pkt_cnt_q + PKT_ONE;
            if (enable) begin
              start = 1'b1;
            end else begin
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tuser_d  = 1'b0;
              busy_d   = 1'b0;
            end
          end else begin
            beat_d  = beat_nx;
            tuser_d = 1'b0;
            tlast_d = (beat_nx == (len_q - LEN_ONE));
            unique case (mode_q)
              2'b10:   tdata_d = {tdata_q[W-2:0], tdata_q[W-1]};
              2'b11:   tdata_d = W'(beat_nx);
              default: tdata_d = d_adv;
            endcase
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // Packet start: latch controls and present beat 0
    if (start) begin
      state_d  = S_SEND;
      mode_d   = mode;
      step_d   = step;
      len_d    = len_in;
      beat_d   = '0;
      tvalid_d = 1'b1;
      tuser_d  = 1'b1;
      busy_d   = 1'b1;
      tlast_d  = (len_in == LEN_ONE);
      unique case (mode)
        2'b10:   tdata_d = DATA_ONE;
        2'b11:   tdata_d = '0;
        default: tdata_d = d_d;
      endcase
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      mode_q     <= '0;
      step_q     <= '0;
      len_q      <= LEN_ONE;
      beat_q     <= '0;
      d_q        <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      busy_q     <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      d_q        <= d_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      busy_q     <= busy_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign busy          = busy_q;
  assign pkt_count     = pkt_cnt_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = '1;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Bench for axis_pattern_gen: an 8-bit instance checked against a beat
// scoreboard, plus a 64-bit instance for the reset/start-up sequence.
module tb_axis_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  step;
  logic [15:0] pkt_len;
  logic        tready;

  logic        busy8, tvalid8, tlast8, tuser8;
  logic [15:0] pcnt8;
  logic [7:0]  tdata8;
  logic [0:0]  tstrb8;

  logic        busy64, tvalid64, tlast64, tuser64;
  logic [15:0] pcnt64;
  logic [63:0] tdata64;
  logic [7:0]  tstrb64;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] model_d;
  int         vecs;
  int         errs;

  axis_pattern_gen #(
    .C_M_AXIS_TDATA_WIDTH(8),
    .C_M_AXIS_START_COUNT(5),
    .C_LEN_WIDTH(16),
    .C_PKTCNT_WIDTH(16)
  ) dut8 (
    .m_axis_aclk(clk),
    .m_axis_aresetn(rst_n),
    .enable(enable),
    .mode(mode),
    .step(step),
    .pkt_len(pkt_len),
    .busy(busy8),
    .pkt_count(pcnt8),
    .m_axis_tvalid(tvalid8),
    .m_axis_tdata(tdata8),
    .m_axis_tstrb(tstrb8),
    .m_axis_tlast(tlast8),
    .m_axis_tuser(tuser8),
    .m_axis_tready(tready)
  );

  axis_pattern_gen #(
    .C_M_AXIS_TDATA_WIDTH(64),
    .C_M_AXIS_START_COUNT(5),
    .C_LEN_WIDTH(16),
    .C_PKTCNT_WIDTH(16)
  ) dut64 (
    .m_axis_aclk(clk),
    .m_axis_aresetn(rst_n),
    .enable(enable),
    .mode(mode),
    .step(step),
    .pkt_len(pkt_len),
    .busy(busy64),
    .pkt_count(pcnt64),
    .m_axis_tvalid(tvalid64),
    .m_axis_tdata(tdata64),
    .m_axis_tstrb(tstrb64),
    .m_axis_tlast(tlast64),
    .m_axis_tuser(tuser64),
    .m_axis_tready(tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of one packet for the 8-bit instance
  task automatic push_pkt(input logic [1:0] m, input logic [7:0] s,
                          input int len);
    int         l;
    logic [7:0] w;
    beat_t      b;
    l = (len == 0) ? 1 : len;
    w = 8'h01;
    for (int i = 0; i < l; i++) begin
      b.user = (i == 0);
      b.last = (i == l - 1);
      case (m)
        2'b00: begin b.data = model_d; model_d = model_d + s; end
        2'b01: begin b.data = model_d; model_d = model_d - s; end
        2'b10: begin b.data = w; w = {w[6:0], w[7]}; end
        default: b.data = i[7:0];
      endcase
      sb.push_back(b);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (5) @(negedge clk);
    vecs++; if (tvalid8 !== 1'b0) begin errs++; $display("FAIL rst_tvalid8: got %b want 0", tvalid8); end
    vecs++; if (tvalid64 !== 1'b0) begin errs++; $display("FAIL rst_tvalid64: got %b want 0", tvalid64); end
    vecs++; if (busy8 !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy8); end
    vecs++; if (pcnt8 !== 16'd0) begin errs++; $display("FAIL rst_pkt_count: got %0d want 0", pcnt8); end
    vecs++; if (tdata64 !== 64'd0) begin errs++; $display("FAIL rst_tdata64: got %h want 0", tdata64); end
    vecs++; if (tstrb64 !== 8'hFF) begin errs++; $display("FAIL tstrb64: got %h want ff", tstrb64); end
    mode    = 2'b00;
    step    = 8'd1;
    pkt_len = 16'd4;
    enable  = 1'b1;
    model_d = 8'h00;
    push_pkt(2'b00, 8'd1, 4);
    push_pkt(2'b00, 8'd1, 4);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (tvalid64 !== 1'b0) begin
        errs++; $display("FAIL init_quiet[%0d]: got tvalid %b want 0", i, tvalid64);
      end
    end
    n = 0;
    while (tvalid64 !== 1'b1 && n < 4) begin
      @(negedge clk); n++;
    end
    vecs++; if (tvalid64 !== 1'b1) begin errs++; $display("FAIL first_tvalid: timeout, got %b want 1", tvalid64); end
    vecs++; if (tdata64 !== 64'd0) begin errs++; $display("FAIL first_tdata64: got %h want 0", tdata64); end
    vecs++; if (tuser64 !== 1'b1) begin errs++; $display("FAIL first_tuser64: got %b want 1", tuser64); end
  endtask

  task automatic test_incr();
    int    got, cyc;
    beat_t e;
    got = 0; cyc = 0;
    while (got < 8 && cyc < 30) begin
      if (tvalid8 && tready) begin
        if (sb.size() == 0) begin
          errs++; vecs++; $display("FAIL incr_sb: unexpected beat %h", tdata8);
        end else begin
          e = sb.pop_front();
          vecs++; if (tdata8 !== e.data) begin errs++; $display("FAIL incr_data[%0d]: got %h want %h", got, tdata8, e.data); end
          vecs++; if (tlast8 !== e.last) begin errs++; $display("FAIL incr_last[%0d]: got %b want %b", got, tlast8, e.last); end
          vecs++; if (tuser8 !== e.user) begin errs++; $display("FAIL incr_user[%0d]: got %b want %b", got, tuser8, e.user); end
        end
        got++;
        if (got == 8) enable = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    vecs++; if (got != 8) begin errs++; $display("FAIL incr_timeout: got %0d beats want 8", got); end
    vecs++; if (cyc != 8) begin errs++; $display("FAIL incr_gap: got %0d cycles want 8", cyc); end
    vecs++; if (pcnt8 !== 16'd2) begin errs++; $display("FAIL incr_pkt_count: got %0d want 2", pcnt8); end
    vecs++; if (tvalid8 !== 1'b0) begin errs++; $display("FAIL incr_idle_tvalid: got %b want 0", tvalid8); end
    vecs++; if (busy8 !== 1'b0) begin errs++; $display("FAIL incr_idle_busy: got %b want 0", busy8); end
  endtask

  task automatic test_stall();
    int    got, cyc;
    bit    stalled;
    beat_t e;
    push_pkt(2'b00, 8'd1, 16);
    mode = 2'b00; step = 8'd1; pkt_len = 16'd16; enable = 1'b1;
    got = 0; cyc = 0; stalled = 0;
    while (got < 16 && cyc < 60) begin
      if (!stalled && tvalid8 && tdata8 == 8'h12) begin
        stalled = 1;
        tready  = 1'b0;
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          vecs++;
          if (tvalid8 !== 1'b1 || tdata8 !== e.data || tlast8 !== e.last || tuser8 !== e.user) begin
            errs++;
            $display("FAIL stall_hold[%0d]: got v%b d%h l%b u%b want v1 d%h l%b u%b",
                     i, tvalid8, tdata8, tlast8, tuser8, e.data, e.last, e.user);
          end
        end
        tready = 1'b1;
      end
      if (tvalid8 && tready) begin
        if (sb.size() == 0) begin
          errs++; vecs++; $display("FAIL stall_sb: unexpected beat %h", tdata8);
        end else begin
          e = sb.pop_front();
          vecs++;
          if (tdata8 !== e.data || tlast8 !== e.last || tuser8 !== e.user) begin
            errs++;
            $display("FAIL stall_beat[%0d]: got d%h l%b u%b want d%h l%b u%b",
                     got, tdata8, tlast8, tuser8, e.data, e.last, e.user);
          end
        end
        got++;
        if (got == 16) enable = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    vecs++; if (got != 16 || !stalled) begin errs++; $display("FAIL stall_timeout: got %0d beats stalled %b want 16 1", got, stalled); end
  endtask

  task automatic test_walk();
    int    got, cyc;
    beat_t e;
    push_pkt(2'b10, 8'd0, 10);
    mode = 2'b10; step = 8'd0; pkt_len = 16'd10; enable = 1'b1;
    got = 0; cyc = 0;
    while (got < 10 && cyc < 30) begin
      if (tvalid8 && tready) begin
        if (sb.size() == 0) begin
          errs++; vecs++; $display("FAIL walk_sb: unexpected beat %h", tdata8);
        end else begin
          e = sb.pop_front();
          vecs++;
          if (tdata8 !== e.data || tlast8 !== e.last || tuser8 !== e.user) begin
            errs++;
            $display("FAIL walk_beat[%0d]: got d%h l%b u%b want d%h l%b u%b",
                     got, tdata8, tlast8, tuser8, e.data, e.last, e.user);
          end
        end
        got++;
        if (got == 10) enable = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    vecs++; if (got != 10) begin errs++; $display("FAIL walk_timeout: got %0d beats want 10", got); end
  endtask

  task automatic test_decr();
    int    got, cyc;
    beat_t e;
    rst_n = 1'b0;
    @(negedge clk);
    vecs++; if (pcnt8 !== 16'd0) begin errs++; $display("FAIL decr_rst_count: got %0d want 0", pcnt8); end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    model_d = 8'h00;
    push_pkt(2'b01, 8'd3, 3);
    push_pkt(2'b01, 8'd3, 0);
    push_pkt(2'b01, 8'd3, 0);
    push_pkt(2'b01, 8'd3, 0);
    mode = 2'b01; step = 8'd3; pkt_len = 16'd3; enable = 1'b1;
    got = 0; cyc = 0;
    while (got < 6 && cyc < 30) begin
      if (tvalid8 && tready) begin
        if (sb.size() == 0) begin
          errs++; vecs++; $display("FAIL decr_sb: unexpected beat %h", tdata8);
        end else begin
          e = sb.pop_front();
          vecs++;
          if (tdata8 !== e.data || tlast8 !== e.last || tuser8 !== e.user) begin
            errs++;
            $display("FAIL decr_beat[%0d]: got d%h l%b u%b want d%h l%b u%b",
                     got, tdata8, tlast8, tuser8, e.data, e.last, e.user);
          end
        end
        got++;
        if (got == 1) pkt_len = 16'd0;
        if (got == 6) enable = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    vecs++; if (got != 6) begin errs++; $display("FAIL decr_timeout: got %0d beats want 6", got); end
    vecs++; if (pcnt8 !== 16'd4) begin errs++; $display("FAIL decr_pkt_count: got %0d want 4", pcnt8); end
  endtask

  task automatic test_enable_drop();
    int    got, cyc;
    beat_t e;
    push_pkt(2'b00, 8'd1, 8);
    mode = 2'b00; step = 8'd1; pkt_len = 16'd8; enable = 1'b1;
    got = 0; cyc = 0;
    while (got < 8 && cyc < 30) begin
      if (tvalid8 && tready) begin
        vecs++; if (busy8 !== 1'b1) begin errs++; $display("FAIL drop_busy[%0d]: got %b want 1", got, busy8); end
        if (sb.size() == 0) begin
          errs++; vecs++; $display("FAIL drop_sb: unexpected beat %h", tdata8);
        end else begin
          e = sb.pop_front();
          vecs++;
          if (tdata8 !== e.data || tlast8 !== e.last || tuser8 !== e.user) begin
            errs++;
            $display("FAIL drop_beat[%0d]: got d%h l%b u%b want d%h l%b u%b",
                     got, tdata8, tlast8, tuser8, e.data, e.last, e.user);
          end
        end
        got++;
        if (got == 2) enable = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    vecs++; if (got != 8) begin errs++; $display("FAIL drop_timeout: got %0d beats want 8", got); end
    repeat (2) @(negedge clk);
    vecs++; if (tvalid8 !== 1'b0) begin errs++; $display("FAIL drop_tvalid: got %b want 0", tvalid8); end
    vecs++; if (busy8 !== 1'b0) begin errs++; $display("FAIL drop_busy_end: got %b want 0", busy8); end
    vecs++; if (pcnt8 !== 16'd5) begin errs++; $display("FAIL drop_pkt_count: got %0d want 5", pcnt8); end
  endtask

  task automatic test_reset_mid();
    int    got, cyc;
    bit    hit;
    beat_t e;
    push_pkt(2'b11, 8'd0, 8);
    mode = 2'b11; step = 8'd0; pkt_len = 16'd8; enable = 1'b1;
    got = 0; cyc = 0; hit = 0;
    while (!hit && cyc < 30) begin
      if (tvalid8 && tdata8 == 8'd3) begin
        hit   = 1;
        rst_n = 1'b0;
        #1;
        vecs++; if (tvalid8 !== 1'b0) begin errs++; $display("FAIL midrst_tvalid: got %b want 0", tvalid8); end
        vecs++; if (pcnt8 !== 16'd0) begin errs++; $display("FAIL midrst_pkt_count: got %0d want 0", pcnt8); end
        vecs++; if (busy8 !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", busy8); end
        vecs++;
        if (tdata8 !== 8'd0 || tlast8 !== 1'b0 || tuser8 !== 1'b0) begin
          errs++; $display("FAIL midrst_outs: got d%h l%b u%b want d00 l0 u0", tdata8, tlast8, tuser8);
        end
        sb.delete();
      end else begin
        if (tvalid8 && tready) begin
          e = sb.pop_front();
          vecs++;
          if (tdata8 !== e.data || tuser8 !== e.user) begin
            errs++; $display("FAIL midrst_beat[%0d]: got d%h u%b want d%h u%b", got, tdata8, tuser8, e.data, e.user);
          end
          got++;
        end
        @(negedge clk); cyc++;
      end
    end
    vecs++; if (!hit) begin errs++; $display("FAIL midrst_timeout: beat 3 not seen, got %0d beats", got); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vecs++; if (tvalid8 !== 1'b0) begin errs++; $display("FAIL midrst_init[%0d]: got tvalid %b want 0", i, tvalid8); end
    end
    enable = 1'b0;
  endtask

  initial begin
    vecs    = 0;
    errs    = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    mode    = 2'b00;
    step    = 8'd0;
    pkt_len = 16'd0;
    tready  = 1'b1;
    model_d = 8'h00;
    test_reset();
    test_incr();
    test_stall();
    test_walk();
    test_decr();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
